// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// word geometry, and the request error check.
package dmem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Misaligned word accesses and indices past the end of the array are both errors.
  function automatic logic addr_error(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// Read data is registered and is the word as it stood before a same-cycle write.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [31:0]           wdata,
  input  logic [WORD_BYTES-1:0] wstrb,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
          if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the CPU MEM stage: accepts one load/store at a time,
// waits WAIT_CYCLES, then presents a response held until the CPU takes it.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            enter_resp;
  logic            accept;

  logic [AW-1:0]   lat_idx;
  logic            lat_we;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_wstrb;
  logic            lat_err;

  logic            ram_en;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [31:0]     ram_wdata;
  logic [3:0]      ram_wstrb;
  logic [31:0]     ram_rdata;
  logic            cur_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      lat_idx   <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= 32'd0;
      lat_wstrb <= 4'd0;
      lat_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_idx   <= req_addr[AW+1:2];
        lat_we    <= req_we;
        lat_wdata <= req_wdata;
        lat_wstrb <= req_wstrb;
        lat_err   <= addr_error(req_addr, 32'(DEPTH_WORDS));
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    enter_resp = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt  = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  // With no wait cycles the RAM access happens on the accept edge itself, so the
  // live request feeds the array in IDLE and the latched copy is used afterwards.
  always_comb begin
    ram_addr  = lat_idx;
    ram_we    = lat_we;
    ram_wdata = lat_wdata;
    ram_wstrb = lat_wstrb;
    cur_err   = lat_err;
    if (state == ST_IDLE) begin
      ram_addr  = req_addr[AW+1:2];
      ram_we    = req_we;
      ram_wdata = req_wdata;
      ram_wstrb = req_wstrb;
      cur_err   = addr_error(req_addr, 32'(DEPTH_WORDS));
    end
    ram_en = enter_resp && !cur_err;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .wstrb(ram_wstrb),
    .rdata(ram_rdata)
  );

  // The RAM read register only updates on entry to RESP, so the response stays stable.
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = rsp_valid && lat_err;
  assign rsp_rdata = (rsp_valid && !lat_we && !lat_err) ? ram_rdata : 32'd0;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the data array.
REQ-002 Parameter WAIT_CYCLES, default 1: extra wait cycles inserted between request accept and response; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  CPU MEM stage presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_wstrb  input  4  store byte enables; bit i enables byte lane i (little-endian).
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  CPU accepts the response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was out of range or misaligned.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0.
REQ-017 A request is accepted on a rising edge with req_valid=1 and req_ready=1; addr, we, wdata, and wstrb SHALL be latched at that edge.
REQ-018 On accept: if WAIT_CYCLES=0, go to RESP; else go to WAIT with a counter loaded to WAIT_CYCLES-1.
REQ-019 In WAIT, the counter SHALL decrement each cycle; when it reaches 0, go to RESP on the next edge.
REQ-020 Minimum request-accept to rsp_valid latency SHALL be WAIT_CYCLES+1 cycles.
REQ-021 Error condition: addr[1:0] != 0, or addr[31:2] >= DEPTH_WORDS.
REQ-022 Store without error: enabled bytes SHALL be written exactly once, on the edge entering RESP; disabled bytes are unchanged; rsp_rdata=0, rsp_err=0.
REQ-023 Store with error: no array write; rsp_err=1.
REQ-024 Load without error: rsp_rdata SHALL equal the array word at addr[31:2] as it stood on the edge entering RESP; rsp_err=0. req_wstrb is ignored.
REQ-025 Load with error: rsp_rdata=0, rsp_err=1.
REQ-026 In RESP, rsp_valid=1; rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1.
REQ-027 Response handshake: on an edge with rsp_valid=1 and rsp_ready=1, return to IDLE; no new request is accepted on that same edge.
REQ-028 Back-to-back throughput SHALL be one request per WAIT_CYCLES+2 cycles when rsp_ready is held at 1.
REQ-029 Outside RESP, rsp_valid=0 and rsp_rdata=0.
REQ-030 req_valid deasserting while not ready SHALL have no effect.

Reset
REQ-031 When rst_n=0, asynchronously: state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, latched request cleared.
REQ-032 Array contents SHALL NOT be reset; simulation may preload them from a hex file.
REQ-033 Reset asserted during WAIT SHALL drop a pending store with no array write. Reset during RESP SHALL discard the response; a store already committed stays committed.
REQ-034 The first acceptance after reset deassertion SHALL occur no earlier than the first rising edge with rst_n=1.

Structure
REQ-035 Shared package dmem_pkg SHALL hold the FSM state enum, the error-check function, and the constant WORD_BYTES=4.
REQ-036 One sub-module, dmem_array, SHALL be used: a synchronous single-port RAM of DEPTH_WORDS x 32 with 4 byte-write enables and a registered read.
REQ-037 The FSM, counter, error check, and response registers SHALL reside in data_mem_responder.

Verification
REQ-038 Word store/load, WAIT_CYCLES=1: store 0xDEADBEEF at 0x10 with wstrb=4'hF, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after each accept.
REQ-039 Byte strobes: preload 0x11223344 at 0x20; store 0xAABBCCDD with wstrb=4'b0101; load 0x20 -> 0x11BB33DD.
REQ-040 Errors: load at 0x22 -> rsp_err=1, rsp_rdata=0. Store to byte address DEPTH_WORDS*4 -> rsp_err=1, and no array word changes.
REQ-041 Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rdata, and rsp_err stable and req_ready=0 throughout; accept completes the cycle rsp_ready rises.
REQ-042 Reset mid-WAIT, WAIT_CYCLES=3: store 0x12345678 at 0x40, pull rst_n low in the 2nd WAIT cycle -> outputs zero immediately, state IDLE, later load of 0x40 returns the old value.
REQ-043 Throughput, WAIT_CYCLES=0: 8 back-to-back loads with rsp_ready=1 -> one response every 2 cycles, data matching the preloaded contents.
